// File: rtl/fsm_vedacao.sv
// Capping station controller: moves the filled bottle on the conveyor, caps it,
// tracks cap stock and the number of finished bottles.
module fsm_vedacao #(
    parameter logic [25:0] TEMPO_ESTEIRA   = 26'd50000000,
    parameter logic [25:0] TEMPO_VEDACAO   = 26'd25000000,
    parameter logic [3:0]  ESTOQUE_INICIAL = 4'd5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_iniciar,
    input  logic       garrafa_cheia,
    input  logic       reabastecer,
    output logic       esteira,
    output logic       vedador_ativo,
    output logic       tarefa_concluida,
    output logic       alarme_sem_tampa,
    output logic [3:0] estoque_tampas,
    output logic [7:0] contador_garrafas
);

    localparam int unsigned TIMER_W = 26;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ESTEIRA   = 3'd1,
        VEDANDO   = 3'd2,
        CONCLUIDO = 3'd3,
        SEM_TAMPA = 3'd4
    } state_t;

    state_t               r_state;
    logic [TIMER_W-1:0]   r_timer;

    state_t               w_next_state;
    logic [TIMER_W-1:0]   w_next_timer;
    logic                 w_esteira_fim;
    logic                 w_vedacao_fim;

    assign w_esteira_fim = (r_state == ESTEIRA) && (r_timer == TEMPO_ESTEIRA - TIMER_W'(1));
    assign w_vedacao_fim = (r_state == VEDANDO) && (r_timer == TEMPO_VEDACAO - TIMER_W'(1));

    // Next-state and timer; the timer is zero on entry to every timed state.
    always_comb begin
        w_next_state = r_state;
        w_next_timer = '0;
        case (r_state)
            IDLE: begin
                if (cmd_iniciar && garrafa_cheia) begin
                    w_next_state = (estoque_tampas != 4'd0) ? ESTEIRA : SEM_TAMPA;
                end
            end
            ESTEIRA: begin
                if (w_esteira_fim) w_next_state = VEDANDO;
                else               w_next_timer = r_timer + TIMER_W'(1);
            end
            VEDANDO: begin
                if (w_vedacao_fim) w_next_state = CONCLUIDO;
                else               w_next_timer = r_timer + TIMER_W'(1);
            end
            CONCLUIDO: begin
                if (!cmd_iniciar) w_next_state = IDLE;
            end
            SEM_TAMPA: begin
                if (reabastecer) w_next_state = cmd_iniciar ? ESTEIRA : IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State, timer, counters; 1-bit outputs are flops decoded from the next state,
    // so they always mirror the registered state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state           <= IDLE;
            r_timer           <= '0;
            estoque_tampas    <= ESTOQUE_INICIAL;
            contador_garrafas <= 8'd0;
            esteira           <= 1'b0;
            vedador_ativo     <= 1'b0;
            tarefa_concluida  <= 1'b0;
            alarme_sem_tampa  <= 1'b0;
        end else begin
            r_state          <= w_next_state;
            r_timer          <= w_next_timer;
            esteira          <= (w_next_state == ESTEIRA);
            vedador_ativo    <= (w_next_state == VEDANDO);
            tarefa_concluida <= (w_next_state == CONCLUIDO);
            alarme_sem_tampa <= (w_next_state == SEM_TAMPA);

            // Refill wins first, then the cap used by a bottle finishing this edge.
            if (reabastecer) begin
                estoque_tampas <= w_vedacao_fim ? (ESTOQUE_INICIAL - 4'd1) : ESTOQUE_INICIAL;
            end else if (w_vedacao_fim) begin
                estoque_tampas <= estoque_tampas - 4'd1;
            end

            if (w_vedacao_fim) begin
                contador_garrafas <= contador_garrafas + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_fsm_vedacao.sv
// Directed bench for fsm_vedacao with short timing parameters (4/3/2).
module tb_fsm_vedacao;

    logic       clk;
    logic       reset;
    logic       cmd_iniciar;
    logic       garrafa_cheia;
    logic       reabastecer;
    logic       esteira;
    logic       vedador_ativo;
    logic       tarefa_concluida;
    logic       alarme_sem_tampa;
    logic [3:0] estoque_tampas;
    logic [7:0] contador_garrafas;

    int n_checks;
    int n_fail;

    fsm_vedacao #(
        .TEMPO_ESTEIRA  (26'd4),
        .TEMPO_VEDACAO  (26'd3),
        .ESTOQUE_INICIAL(4'd2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_iniciar      (cmd_iniciar),
        .garrafa_cheia    (garrafa_cheia),
        .reabastecer      (reabastecer),
        .esteira          (esteira),
        .vedador_ativo    (vedador_ativo),
        .tarefa_concluida (tarefa_concluida),
        .alarme_sem_tampa (alarme_sem_tampa),
        .estoque_tampas   (estoque_tampas),
        .contador_garrafas(contador_garrafas)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full cycle from IDLE back to IDLE; optional refill on the final idle edge.
    task automatic run_cycle(input logic refill);
        cmd_iniciar   = 1'b1;
        garrafa_cheia = 1'b1;
        repeat (8) tick();
        cmd_iniciar   = 1'b0;
        garrafa_cheia = 1'b0;
        reabastecer   = refill;
        tick();
        reabastecer   = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b0;
        cmd_iniciar   = 1'b0;
        garrafa_cheia = 1'b0;
        reabastecer   = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();

        chk("rst_esteira", 32'(esteira), 32'd0);
        chk("rst_estoque", 32'(estoque_tampas), 32'd2);
        chk("rst_contador", 32'(contador_garrafas), 32'd0);
        chk("rst_alarme", 32'(alarme_sem_tampa), 32'd0);

        // Normal cycle, with garrafa_cheia dropped mid-conveyor (must be ignored).
        cmd_iniciar   = 1'b1;
        garrafa_cheia = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 1) garrafa_cheia = 1'b0;
            chk("norm_esteira", 32'(esteira), 32'(i <= 3));
            chk("norm_vedador", 32'(vedador_ativo), 32'((i >= 4) && (i <= 6)));
            chk("norm_done", 32'(tarefa_concluida), 32'(i == 7));
        end
        chk("norm_estoque", 32'(estoque_tampas), 32'd1);
        chk("norm_contador", 32'(contador_garrafas), 32'd1);

        // Handshake: done held while cmd stays high.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hs_hold", 32'(tarefa_concluida), 32'd1);
        end
        cmd_iniciar = 1'b0;
        tick();
        chk("hs_drop", 32'(tarefa_concluida), 32'd0);
        chk("hs_idle_esteira", 32'(esteira), 32'd0);

        // Empty stock.
        run_cycle(1'b0);
        chk("emp_estoque0", 32'(estoque_tampas), 32'd0);
        chk("emp_contador", 32'(contador_garrafas), 32'd2);
        cmd_iniciar   = 1'b1;
        garrafa_cheia = 1'b1;
        repeat (2) begin
            tick();
            chk("emp_alarme", 32'(alarme_sem_tampa), 32'd1);
            chk("emp_esteira", 32'(esteira), 32'd0);
        end
        reabastecer = 1'b1;
        tick();
        reabastecer = 1'b0;
        chk("emp_refill_estoque", 32'(estoque_tampas), 32'd2);
        chk("emp_refill_esteira", 32'(esteira), 32'd1);
        chk("emp_refill_alarme", 32'(alarme_sem_tampa), 32'd0);
        repeat (7) tick();
        chk("emp_done", 32'(tarefa_concluida), 32'd1);
        chk("emp_estoque1", 32'(estoque_tampas), 32'd1);
        chk("emp_contador3", 32'(contador_garrafas), 32'd3);
        cmd_iniciar   = 1'b0;
        garrafa_cheia = 1'b0;
        tick();

        // Refill on the final capping edge: refill then consume.
        cmd_iniciar   = 1'b1;
        garrafa_cheia = 1'b1;
        repeat (7) tick();
        reabastecer = 1'b1;
        tick();
        reabastecer = 1'b0;
        chk("sim_estoque", 32'(estoque_tampas), 32'd1);
        chk("sim_contador", 32'(contador_garrafas), 32'd4);
        chk("sim_done", 32'(tarefa_concluida), 32'd1);
        cmd_iniciar   = 1'b0;
        garrafa_cheia = 1'b0;
        tick();

        // Refill in IDLE: stock reloaded, no state change.
        reabastecer = 1'b1;
        tick();
        reabastecer = 1'b0;
        chk("idle_refill_estoque", 32'(estoque_tampas), 32'd2);
        chk("idle_refill_esteira", 32'(esteira), 32'd0);

        // Counter wrap.
        repeat (251) run_cycle(1'b1);
        chk("wrap_255", 32'(contador_garrafas), 32'd255);
        run_cycle(1'b1);
        chk("wrap_0", 32'(contador_garrafas), 32'd0);

        // Asynchronous reset mid-conveyor.
        cmd_iniciar   = 1'b1;
        garrafa_cheia = 1'b1;
        repeat (2) tick();
        chk("ar_pre_esteira", 32'(esteira), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("ar_esteira", 32'(esteira), 32'd0);
        chk("ar_estoque", 32'(estoque_tampas), 32'd2);
        chk("ar_contador", 32'(contador_garrafas), 32'd0);
        cmd_iniciar   = 1'b0;
        garrafa_cheia = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("ar_idle_esteira", 32'(esteira), 32'd0);
        chk("ar_idle_vedador", 32'(vedador_ativo), 32'd0);
        chk("ar_idle_done", 32'(tarefa_concluida), 32'd0);
        cmd_iniciar   = 1'b1;
        garrafa_cheia = 1'b1;
        tick();
        chk("ar_restart", 32'(esteira), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
